// File: rtl/imem_loader.sv
// Instruction-memory program loader: framed little-endian byte stream in, 32-bit
// word writes out at consecutive addresses from 0, validated by a trailing XOR checksum.
module imem_loader #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [AW:0]   word_count_o
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StCheck, StDone, StErr
  } state_e;

  localparam logic [16:0] MaxLen = 17'(1) << AW;

  state_e        state_q, state_d;
  logic [15:0]   len_q;
  logic [1:0]    idx_q;
  logic [7:0]    csum_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          byte_ready_q, mem_we_q, busy_q, done_q, error_q;

  logic          accept;
  logic          start_ok;
  logic [15:0]   len_next;
  logic [15:0]   count_inc;

  // byte_ready_q tracks state_q exactly, so accept never depends combinationally on an output path
  assign accept    = byte_valid_i && byte_ready_q;
  assign start_ok  = start_i && (state_q inside {StIdle, StDone, StErr});
  assign len_next  = {byte_data_i, len_q[7:0]};
  assign count_inc = 16'(count_q) + 16'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLenLo;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: begin
        if (accept) begin
          if ({1'b0, len_next} > MaxLen) begin
            state_d = StErr;
          end else if (len_next == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData:  if (accept && idx_q == 2'd3) state_d = StWrite;
      StWrite: state_d = (count_inc == len_q) ? StCheck : StData;
      StCheck: if (accept) state_d = (byte_data_i == csum_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= state_d inside {StLenLo, StLenHi, StData, StCheck};
      busy_q       <= state_d inside {StLenLo, StLenHi, StData, StWrite, StCheck};
      mem_we_q     <= (state_d == StWrite);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StErr);

      if (start_ok) begin
        len_q   <= '0;
        idx_q   <= '0;
        csum_q  <= '0;
        count_q <= '0;
      end

      if (accept) begin
        unique case (state_q)
          StLenLo: len_q[7:0]  <= byte_data_i;
          StLenHi: len_q[15:8] <= byte_data_i;
          StData: begin
            // Shift in from the top so byte k lands in bits [8k+7:8k] after four bytes
            wdata_q <= {byte_data_i, wdata_q[31:8]};
            csum_q  <= csum_q ^ byte_data_i;
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) addr_q <= count_q[AW-1:0];
          end
          default: ;
        endcase
      end

      if (state_q == StWrite) count_q <= count_q + {{AW{1'b0}}, 1'b1};
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a frame-level
// model of the expected writes, completion status and word count.
module tb_imem_loader;
  localparam int unsigned AW = 10;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          bv = 1'b0;
  logic [7:0]    bd = 8'h00;
  logic          byte_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] wr_q[$];
  int done_cnt = 0;

  imem_loader #(.AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .byte_valid_i(bv),
    .byte_data_i (bd),
    .byte_ready_o(byte_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  // Memory-side observer: records every write and every done pulse
  always @(posedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic make_frame(input int n, input bit bad, output bq_t fr);
    logic [7:0] x;
    logic [31:0] w;
    fr = {};
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        fr.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    fr.push_back(bad ? ~x : x);
  endtask

  // Offers one byte until accepted; random valid gaps and random start pokes if requested
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bd    = b;
      bv    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      acc   = bv && byte_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bv    = 1'b0;
    start = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: observed=byte %0h not accepted expected=accepted", b);
    end
  endtask

  task automatic do_load(input bq_t fr, input bit gaps, input bit poke, input string tag);
    int n;
    bit over, exp_done, ok;
    int consumed;
    logic [7:0] x;
    logic [31:0] exp_w[$];
    n = int'({fr[1], fr[0]});
    over = (n > (1 << AW));
    x = 8'h00;
    if (!over) begin
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
        for (int k = 0; k < 4; k++) x ^= fr[2+4*i+k];
      end
    end
    exp_done = !over && (fr[2+4*n] == x);
    consumed = over ? 2 : 3 + 4 * n;

    wr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".ready_after_start"}, {62'd0, byte_ready, busy}, 64'd3);
    check({tag, ".error_cleared"}, {63'd0, error}, 64'd0);

    ok = 1'b1;
    for (int i = 0; i < consumed && ok; i++) begin
      send_byte(fr[i], gaps, poke, ok);
      if (ok && i >= 2 && i < consumed - 1 && ((i - 2) % 4) == 3)
        check({tag, ".we_after_word"}, {62'd0, mem_we, byte_ready}, 64'd2);
    end

    check({tag, ".done_now"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, ".error_now"}, {63'd0, error}, {63'd0, !exp_done});
    @(posedge clk);
    #1;
    check({tag, ".done_one_cycle"}, {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".error_held"}, {63'd0, error}, {63'd0, !exp_done});
    check({tag, ".busy_idle"}, {62'd0, busy, byte_ready}, 64'd0);
    check({tag, ".done_count"}, 64'(done_cnt), exp_done ? 64'd1 : 64'd0);
    check({tag, ".word_count"}, 64'(word_count), over ? 64'd0 : 64'(n));
    check({tag, ".num_writes"}, 64'(wr_q.size()), over ? 64'd0 : 64'(n));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      check({tag, ".write"}, 64'(wr_q[i]), 64'({AW'(i), exp_w[i]}));
  endtask

  initial begin
    bq_t fr;
    bit ok;

    // Reset asserted mid-cycle: outputs clear immediately
    #3 rst = 1'b1;
    #1;
    check("reset_outputs", {byte_ready, mem_we, busy, done, error, mem_addr, mem_wdata, word_count},
          64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_ready", {62'd0, byte_ready, busy}, 64'd0);

    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    do_load(fr, 1'b0, 1'b0, "nominal");
    check("nominal.w0", 64'(wr_q[0]), {22'd0, 10'd0, 32'h12345678});
    check("nominal.w1", 64'(wr_q[1]), {22'd0, 10'd1, 32'hDEADBEEF});

    fr[10] = 8'h00;
    do_load(fr, 1'b0, 1'b0, "bad_csum");

    fr = '{8'h01, 8'h04};
    do_load(fr, 1'b0, 1'b0, "over_len");

    fr = '{8'h00, 8'h00, 8'h00};
    do_load(fr, 1'b0, 1'b0, "zero_len");
    fr = '{8'h00, 8'h00, 8'h01};
    do_load(fr, 1'b0, 1'b0, "zero_len_bad");

    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    do_load(fr, 1'b1, 1'b1, "gaps_poke");

    for (int r = 0; r < 8; r++) begin
      make_frame($urandom_range(1, 9), ($urandom_range(0, 3) == 0), fr);
      do_load(fr, 1'b1, 1'b1, "random");
    end

    make_frame(1 << AW, 1'b0, fr);
    do_load(fr, 1'b0, 1'b0, "full");
    check("full.last_addr", 64'(wr_q[wr_q.size()-1][AW+31:32]), 64'h3FF);

    // Reset right after the first write aborts the load
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    wr_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(fr[i], 1'b0, 1'b0, ok);
    check("abort.we", {63'd0, mem_we}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.outputs", {byte_ready, mem_we, busy, done, error, mem_addr, mem_wdata, word_count},
          64'd0);
    bv = 1'b1;
    bd = 8'hEF;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bv = 1'b0;
    check("abort.one_write", 64'(wr_q.size()), 64'd1);
    check("abort.idle", {61'd0, byte_ready, busy, error}, 64'd0);
    do_load(fr, 1'b1, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory program loader: the write-side counterpart of the instruction ROM's read port. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into the instruction memory at consecutive word addresses starting at 0. A trailing XOR checksum validates the image. The loader sits between the host byte source (UART receiver or testbench) and the instruction RAM's write port.

## Interface
- AW, 10, word-address width; capacity 2^AW words (1024 words = 4 KB)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready at the clock edge
- mem_we  out  1  instruction-memory write strobe, single cycle per word
- mem_addr  out  AW  word address
- mem_wdata  out  32  instruction word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  length or checksum failure; held until next start or reset
- word_count  out  AW+1  words written in the current load

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4·N payload bytes, 1 checksum byte = XOR of all payload bytes (length bytes excluded).
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR + start → LEN_LO; word_count, byte index, checksum accumulator and error are cleared.
- LEN_LO: accept byte → N[7:0]; → LEN_HI.
- LEN_HI: accept byte → N[15:8]; if N > 2^AW → ERR; if N == 0 → CHECK; else → DATA.
- DATA: accepted byte k (k = 0..3) goes to word bits [8k+7:8k]; each byte XORed into the accumulator; after the 4th byte → WRITE.
- WRITE: mem_we=1, mem_addr=word_count[AW-1:0], mem_wdata=assembled word; word_count increments at the end of the cycle; if the new count == N → CHECK, else → DATA.
- CHECK: accept byte; equal to accumulator → DONE, else → ERR.
- DONE: done=1 for exactly one cycle, then → IDLE unless start is asserted in that cycle (→ LEN_LO).
- ERR: error=1, remains in ERR until start or rst. Words already written stay in memory.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA, CHECK. busy=1 in LEN_LO, LEN_HI, DATA, WRITE, CHECK.
- start while busy is ignored. byte_valid in IDLE/DONE/ERR/WRITE is not consumed.
- mem_addr/mem_wdata are don't-care when mem_we=0, but are registered and must not glitch during WRITE.

## Timing
- Reset (async, immediate): state IDLE; byte_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, word_count = 0; accumulator 0.
- Reset mid-load aborts with no further writes; no done/error pulse.
- All outputs are registered or decoded from registered state only; no combinational path from byte_valid/byte_data to any output.
- One byte per cycle maximum; a full word costs 4 accept cycles + 1 WRITE cycle (byte_ready low during WRITE), so peak throughput is 4 bytes per 5 cycles.
- Gaps in byte_valid stall the FSM in place; no timeout.
- start → byte_ready high on the next cycle.
- Last payload byte accepted at edge t → mem_we high in cycle t+1 → CHECK (byte_ready) at t+2.
- Checksum byte accepted at edge t → done or error high in cycle t+1.
- N == 2^AW is legal: the last write goes to address 2^AW−1, and word_count reaches 2^AW without wrapping.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately; state IDLE; byte_ready=0.
- Nominal: start, bytes 02 00 78 56 34 12 EF BE AD DE 2A → writes (0, 0x12345678), (1, 0xDEADBEEF); done pulses once; word_count=2; error=0.
- Bad checksum: same frame with final byte 00 → both writes occur; error=1 and held; done never asserted.
- Over-length: start, bytes 01 04 (N=1025) → ERR after LEN_HI; no mem_we; error=1. Also check N=1024 with 4096 payload bytes: last write addr 0x3FF, done.
- Zero length: start, bytes 00 00 00 → done, no mem_we, word_count=0; with checksum 01 instead → error.
- Handshake/abort: random byte_valid gaps give the same writes as the nominal case; start pulses during busy are ignored; rst after the first write → no second write, outputs 0, and a fresh start then loads correctly.
